// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end to a shared 16-bit log shifter
// (SLL/SRA/ROL/SRL) with a single-entry valid/ready result register.
module shift_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  input  logic [3:0]  req0_shamt,
  input  logic [1:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req1_shamt,
  input  logic [1:0]  req1_op,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_id,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRA = 2'b01,
    OP_ROL = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic        r_out_id;
  logic        r_prio;

  logic        w_can_accept;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_xfer;
  logic        w_sel;
  logic [15:0] w_opnd;
  logic [3:0]  w_shamt;
  op_e         w_op;
  logic [15:0] w_shift;

  function automatic logic [15:0] shift_stage(input logic [15:0] x, input op_e op,
                                              input int unsigned s);
    logic [15:0] y;
    case (op)
      OP_SLL:  y = x << s;
      OP_SRA:  y = $signed(x) >>> s;
      OP_ROL:  y = (x << s) | (x >> (16 - s));
      default: y = x >> s;
    endcase
    return y;
  endfunction

  assign w_can_accept = !r_out_valid || out_ready;

  // Tie goes to r_prio; reset forces both readys low so nothing transfers.
  assign w_gnt0 = !rst && w_can_accept && req0_valid && (!req1_valid || !r_prio);
  assign w_gnt1 = !rst && w_can_accept && req1_valid && (!req0_valid ||  r_prio);
  assign w_xfer = w_gnt0 || w_gnt1;
  assign w_sel  = w_gnt1;

  assign w_opnd  = w_sel ? req1_data  : req0_data;
  assign w_shamt = w_sel ? req1_shamt : req0_shamt;
  assign w_op    = op_e'(w_sel ? req1_op : req0_op);

  always_comb begin
    w_shift = w_opnd;
    for (int unsigned k = 0; k < 4; k++) begin
      if (w_shamt[k]) w_shift = shift_stage(w_shift, w_op, 32'd1 << k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 1'b0;
      r_prio      <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_shift;
      r_out_id    <= w_sel;
      r_prio      <= ~w_sel;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_id     = r_out_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: driver pushes expected {id,data} on each
// expected grant; a negedge monitor pops and compares on every output handshake.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_id;
  logic        out_ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [16:0] exp_q[$];

  localparam logic [1:0] SLL = 2'b00, SRA = 2'b01, ROL = 2'b10, SRL = 2'b11;

  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_shamt(req0_shamt),
    .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_shamt(req1_shamt),
    .req1_op(req1_op), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_req(input int unsigned n, input logic v, input logic [15:0] d,
                         input logic [3:0] s, input logic [1:0] o);
    if (n == 0) begin
      req0_valid = v; req0_data = d; req0_shamt = s; req0_op = o;
    end else begin
      req1_valid = v; req1_data = d; req1_shamt = s; req1_op = o;
    end
  endtask

  // Runs one cycle with inputs already driven; checks grants, queues the result.
  task automatic go(input string nm, input logic er0, input logic er1,
                    input logic [15:0] eres);
    @(negedge clk);
    chk({nm, "_rdy0"}, {16'h0, req0_ready}, {16'h0, er0});
    chk({nm, "_rdy1"}, {16'h0, req1_ready}, {16'h0, er1});
    if (er0) exp_q.push_back({1'b0, eres});
    if (er1) exp_q.push_back({1'b1, eres});
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake on the output consumes one expected result.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_onehot", {16'h0, req0_ready & req1_ready}, 17'h0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL mon_unexpected: got %h expected none", {out_id, out_data});
        end else begin
          chk("mon_result", {out_id, out_data}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    set_req(0, 1'b0, 16'h0, 4'h0, SLL);
    set_req(1, 1'b0, 16'h0, 4'h0, SLL);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", {16'h0, out_valid}, 17'h0);
    chk("rst_data",  {1'b0, out_data},   17'h0);
    chk("rst_id",    {16'h0, out_id},    17'h0);

    // First op and same-cycle ready.
    out_ready = 1'b1;
    set_req(0, 1'b1, 16'h8000, 4'd15, SRL);
    go("srl15", 1'b1, 1'b0, 16'h0001);
    chk("srl15_valid", {16'h0, out_valid}, 17'h1);
    chk("srl15_data", {out_id, out_data}, 17'h0_0001);

    set_req(0, 1'b0, 16'h0, 4'h0, SLL);
    set_req(1, 1'b1, 16'h8000, 4'd4, SRA);  go("sra4", 1'b0, 1'b1, 16'hF800);
    set_req(1, 1'b1, 16'h1234, 4'd4, ROL);  go("rol4", 1'b0, 1'b1, 16'h2341);
    set_req(1, 1'b0, 16'h0, 4'h0, SLL);
    set_req(0, 1'b1, 16'h0001, 4'd15, SLL); go("sll15", 1'b1, 1'b0, 16'h8000);
    for (int i = 0; i < 4; i++) begin
      set_req(i % 2, 1'b1, 16'hA5A5, 4'd0, 2'(i));
      set_req((i + 1) % 2, 1'b0, 16'h0, 4'h0, SLL);
      go("sh0", (i % 2) == 0, (i % 2) == 1, 16'hA5A5);
    end

    // Drain without refill.
    set_req(0, 1'b0, 16'h0, 4'h0, SLL);
    set_req(1, 1'b0, 16'h0, 4'h0, SLL);
    go("drain", 1'b0, 1'b0, 16'h0);
    chk("drain_valid", {16'h0, out_valid}, 17'h0);

    // Fairness from reset.
    rst = 1'b1;
    set_req(0, 1'b1, 16'h0003, 4'd1, SLL);
    set_req(1, 1'b1, 16'h0100, 4'd4, SRL);
    go("rst_a", 1'b0, 1'b0, 16'h0);
    exp_q.delete();
    rst = 1'b0;
    go("rr0", 1'b1, 1'b0, 16'h0006);
    go("rr1", 1'b0, 1'b1, 16'h0010);
    go("rr2", 1'b1, 1'b0, 16'h0006);
    go("rr3", 1'b0, 1'b1, 16'h0010);

    // Back-pressure: hold three cycles, then drain+refill in one cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      go("bp", 1'b0, 1'b0, 16'h0);
      chk("bp_valid", {16'h0, out_valid}, 17'h1);
      chk("bp_hold", {out_id, out_data}, 17'h1_0010);
    end
    out_ready = 1'b1;
    go("bp_rel", 1'b1, 1'b0, 16'h0006);
    chk("bp_rel_valid", {16'h0, out_valid}, 17'h1);
    chk("bp_rel_data", {out_id, out_data}, 17'h0_0006);

    // Reset while a result is pending and both requesters wait (prio is 1 here).
    rst = 1'b1;
    go("rst_b", 1'b0, 1'b0, 16'h0);
    exp_q.delete();
    rst = 1'b0;
    chk("rst_b_valid", {16'h0, out_valid}, 17'h0);
    chk("rst_b_data", {out_id, out_data}, 17'h0);
    go("post_rst_tie", 1'b1, 1'b0, 16'h0006);
    set_req(0, 1'b0, 16'h0, 4'h0, SLL);
    set_req(1, 1'b0, 16'h0, 4'h0, SLL);
    go("final_drain", 1'b0, 1'b0, 16'h0);
    chk("final_valid", {16'h0, out_valid}, 17'h0);
    @(negedge clk);
    chk("queue_empty", 17'(exp_q.size()), 17'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 16-bit shift datapath (SLL/SRA/ROL/SRL, 4-bit shift amount) between two requesters, such as the ALU-issue path and the address/immediate-formatting path. A round-robin arbiter grants one requester per cycle using a valid/ready handshake. The shift result is captured in a single-entry output register with its own valid/ready handshake, so a stalled consumer back-pressures both requesters. The block sits between the decode-side requesters and the execute-stage writeback mux.

## Interface
- No parameters; data width fixed at 16, shift amount at 4 bits.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_data  in  16  operand
- req0_shamt  in  4  shift amount 0..15
- req0_op  in  2  00 SLL, 01 SRA, 10 ROL, 11 SRL
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid / req1_data / req1_shamt / req1_op / req1_ready  same as requester 0
- out_valid  out  1  result register holds a result
- out_data  out  16  shifted result
- out_id  out  1  requester that produced out_data
- out_ready  in  1  consumer takes the result this cycle

## Operation
- Result register state: out_valid, out_data, out_id. Round-robin pointer `prio` is 1 bit and names the requester that wins a tie.
- can_accept = !out_valid | out_ready.
- Grant, combinational:
  - If can_accept and exactly one reqN_valid, grant N.
  - If can_accept and both are valid, grant `prio`.
  - If can_accept is 0, grant nobody.
- reqN_ready = grant to N. At most one ready is high per cycle. A ready may depend on the same-cycle valid.
- Handshake: a transfer occurs when reqN_valid & reqN_ready. A requester must hold its valid and payload stable until its transfer occurs.
- On a transfer from N:
  - The result of the shift of reqN_data by reqN_shamt under reqN_op is written to out_data.
  - out_id is set to N and out_valid is set to 1.
  - prio is set to ~N.
- On out_valid & out_ready with no new transfer in the same cycle, out_valid is cleared. out_data and out_id hold their last values.
- Simultaneous drain and accept in one cycle: the register is overwritten with the new result and out_valid stays 1.
- prio changes only on a transfer.
- Shift semantics:
  - SLL zero-fills from bit 0.
  - SRL zero-fills from bit 15.
  - SRA replicates bit 15.
  - ROL moves bits shifted out of bit 15 into bit 0.
  - shamt = 0 returns the operand unchanged for all ops.
- The shift datapath is a 4-stage log shifter (stages of 1, 2, 4 and 8), each stage selected by one shamt bit. It is purely combinational inside the block and is not registered.

## Timing
- Reset: out_valid=0, out_data=16'h0000, out_id=0, prio=0. Outputs take these values at the first clock edge with rst=1.
- reqN_ready is 0 whenever rst=1.
- While rst=1, a transfer is ignored and no state changes except the reset values.
- Latency: a transfer at edge T makes the result visible on out_data/out_valid after edge T. Latency is 1 cycle.
- Throughput: 1 operation per cycle while out_ready is held high.
- Back-pressure: with out_valid=1 and out_ready=0, both readys are 0 and the register holds.
- Fairness: with both requesters continuously valid and out_ready=1, grants alternate 0,1,0,1... after reset. No requester waits more than 1 extra accepted operation.
- Reset mid-operation: a pending result is discarded and out_valid=0 in the next cycle.

## Test plan
- Reset, then req0 SRL 16'h8000 shamt 15 with out_ready=1:
  - req0_ready is 1 in the same cycle.
  - Next cycle: out_valid=1, out_data=16'h0001, out_id=0.
- Single requester, all ops with one operand each:
  - SRA 16'h8000 shamt 4 -> 16'hF800.
  - ROL 16'h1234 shamt 4 -> 16'h2341.
  - SLL 16'h0001 shamt 15 -> 16'h8000.
  - Any op with shamt 0 on 16'hA5A5 -> 16'hA5A5.
- Both requesters valid every cycle from reset, out_ready=1:
  - out_id sequence is 0,1,0,1.
  - req0_ready and req1_ready are never high together.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 and both requesters valid.
  - Both readys stay 0 and out_data is held.
  - When out_ready rises, a new transfer occurs in that same cycle and out_valid stays 1.
- Drain without refill: out_valid=1, out_ready=1, no requester valid -> out_valid=0 next cycle.
- Assert rst for 1 cycle while out_valid=1 and both requesters valid:
  - out_valid=0 and prio=0 next cycle.
  - The first post-reset tie is granted to requester 0.
